// File: rtl/coin_input_module.sv
// Coin acceptor front end: synchronizes and debounces coin and cancel sensors,
// then keeps the registered credit under coin, deduction and clear requests.
module coin_input_module #(
   parameter int         DEBOUNCE_CYCLES = 4,
   parameter logic [4:0] MAX_AMOUNT      = 5'd31
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       coin_1_raw,
   input  logic       coin_2_raw,
   input  logic       coin_5_raw,
   input  logic       cancel_raw,
   input  logic       clear,
   input  logic       deduct_valid,
   input  logic [4:0] deduct_value,
   output logic [4:0] current_amount,
   output logic       coin_valid,
   output logic [4:0] coin_value,
   output logic       coin_reject,
   output logic       deduct_ack,
   output logic       deduct_err,
   output logic       cancel_req
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CLAST = CW'(DEBOUNCE_CYCLES - 1);

   logic [3:0]    raw;
   logic [3:0]    s1;
   logic [3:0]    s2;
   logic [3:0]    deb;
   logic [3:0]    deb_d;
   logic [3:0]    rise;
   logic [CW-1:0] cnt [4];

   assign raw  = {cancel_raw, coin_5_raw, coin_2_raw, coin_1_raw};
   assign rise = deb & ~deb_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         s1    <= '0;
         s2    <= '0;
         deb   <= '0;
         deb_d <= '0;
         for (int i = 0; i < 4; i++) cnt[i] <= '0;
      end else begin
         s1    <= raw;
         s2    <= s1;
         deb_d <= deb;
         for (int i = 0; i < 4; i++) begin
            if (s2[i] != deb[i]) begin
               // flip on the DEBOUNCE_CYCLES-th consecutive differing sample
               if (cnt[i] == CLAST) begin
                  deb[i] <= s2[i];
                  cnt[i] <= '0;
               end else begin
                  cnt[i] <= cnt[i] + 1'b1;
               end
            end else begin
               cnt[i] <= '0;
            end
         end
      end
   end

   logic [1:0] ncoins;
   logic [4:0] val;
   logic [5:0] after;
   logic [5:0] sum;
   logic [4:0] amt_n;
   logic [4:0] cval_n;
   logic       cv_n;
   logic       rej_n;
   logic       ack_n;
   logic       err_n;

   always_comb begin
      ncoins = {1'b0, rise[0]} + {1'b0, rise[1]} + {1'b0, rise[2]};
      val    = 5'd0;
      if (rise[0])      val = 5'd1;
      else if (rise[1]) val = 5'd2;
      else if (rise[2]) val = 5'd5;
      after  = {1'b0, current_amount};
      sum    = 6'd0;
      amt_n  = current_amount;
      cval_n = 5'd0;
      cv_n   = 1'b0;
      rej_n  = 1'b0;
      ack_n  = 1'b0;
      err_n  = 1'b0;
      if (clear) begin
         amt_n = 5'd0;
         rej_n = (ncoins != 2'd0);
         err_n = deduct_valid;
      end else begin
         if (deduct_valid) begin
            if (deduct_value <= current_amount) begin
               after = {1'b0, current_amount} - {1'b0, deduct_value};
               ack_n = 1'b1;
            end else begin
               err_n = 1'b1;
            end
         end
         amt_n = after[4:0];
         sum   = after + {1'b0, val};
         if (ncoins >= 2'd2) begin
            rej_n = 1'b1;
         end else if (ncoins == 2'd1) begin
            if (sum <= {1'b0, MAX_AMOUNT}) begin
               amt_n  = sum[4:0];
               cv_n   = 1'b1;
               cval_n = val;
            end else begin
               rej_n = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         current_amount <= 5'd0;
         coin_valid     <= 1'b0;
         coin_value     <= 5'd0;
         coin_reject    <= 1'b0;
         deduct_ack     <= 1'b0;
         deduct_err     <= 1'b0;
         cancel_req     <= 1'b0;
      end else begin
         current_amount <= amt_n;
         coin_valid     <= cv_n;
         coin_value     <= cval_n;
         coin_reject    <= rej_n;
         deduct_ack     <= ack_n;
         deduct_err     <= err_n;
         cancel_req     <= rise[3];
      end
   end

endmodule

// File: tb/tb_coin_input_module.sv
// Directed bench for coin_input_module: latency, debounce,
// credit limits, deductions, clear and reset behaviour.
module tb_coin_input_module;

   logic       clk;
   logic       reset;
   logic       c1, c2, c5, cancel_raw;
   logic       clear;
   logic       deduct_valid;
   logic [4:0] deduct_value;
   logic [4:0] current_amount;
   logic       coin_valid;
   logic [4:0] coin_value;
   logic       coin_reject;
   logic       deduct_ack;
   logic       deduct_err;
   logic       cancel_req;

   int n_run  = 0;
   int n_fail = 0;

   coin_input_module #(.DEBOUNCE_CYCLES(4), .MAX_AMOUNT(5'd31)) dut (
      .clk(clk), .reset(reset),
      .coin_1_raw(c1), .coin_2_raw(c2), .coin_5_raw(c5),
      .cancel_raw(cancel_raw), .clear(clear),
      .deduct_valid(deduct_valid), .deduct_value(deduct_value),
      .current_amount(current_amount), .coin_valid(coin_valid),
      .coin_value(coin_value), .coin_reject(coin_reject),
      .deduct_ack(deduct_ack), .deduct_err(deduct_err),
      .cancel_req(cancel_req)
   );

   initial clk = 0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // raw high after edge N-1 -> event registered at edge N+6
   task automatic press(input logic [2:0] m, input logic dv,
                        input logic [4:0] dval, input logic clr);
      {c5, c2, c1} = m;
      repeat (6) tick();
      check("no_early_event", {31'd0, coin_valid | coin_reject}, 0);
      deduct_valid = dv;
      deduct_value = dval;
      clear        = clr;
      tick();
      deduct_valid = 0;
      clear        = 0;
   endtask

   task automatic release_coins();
      {c5, c2, c1} = 3'b000;
      repeat (12) tick();
   endtask

   task automatic coin(input logic [2:0] m);
      press(m, 1'b0, 5'd0, 1'b0);
      release_coins();
   endtask

   task automatic deduct(input logic [4:0] v);
      deduct_valid = 1;
      deduct_value = v;
      tick();
      deduct_valid = 0;
   endtask

   int pulses;

   initial begin
      reset = 1; c1 = 0; c2 = 0; c5 = 0; cancel_raw = 0;
      clear = 0; deduct_valid = 0; deduct_value = 0;
      repeat (3) tick();
      check("rst_amount", current_amount, 0);
      check("rst_pulses", {coin_valid, coin_reject, deduct_ack,
                           deduct_err, cancel_req}, 0);
      reset = 0;
      tick();

      // coin 5: event at exactly 2+DEBOUNCE_CYCLES, once while held
      press(3'b100, 1'b0, 5'd0, 1'b0);
      check("c5_valid", coin_valid, 1);
      check("c5_value", coin_value, 5);
      check("c5_amount", current_amount, 5);
      pulses = 0;
      repeat (10) begin
         tick();
         pulses += int'(coin_valid);
      end
      check("c5_single", pulses, 0);
      check("c5_value_idle", coin_value, 0);
      release_coins();

      // bouncy coin 2
      c2 = 1; tick(); c2 = 0; tick(); c2 = 1; tick(); c2 = 0; tick();
      c2 = 1;
      pulses = 0;
      repeat (20) begin
         tick();
         pulses += int'(coin_valid);
      end
      check("bounce_pulses", pulses, 1);
      check("bounce_amount", current_amount, 7);
      release_coins();

      // deduct 5 with coin 1 in same cycle: 7-5+1
      press(3'b001, 1'b1, 5'd5, 1'b0);
      check("dc_ack", deduct_ack, 1);
      check("dc_valid", coin_valid, 1);
      check("dc_amount", current_amount, 3);
      release_coins();
      deduct(5'd4);
      check("ded_err", deduct_err, 1);
      check("ded_err_ack", deduct_ack, 0);
      check("ded_err_amount", current_amount, 3);
      deduct(5'd3);
      check("ded_exact_ack", deduct_ack, 1);
      check("ded_exact_amount", current_amount, 0);
      tick();
      check("ack_one_cycle", deduct_ack, 0);

      // cancel press
      cancel_raw = 1;
      pulses = 0;
      repeat (12) begin
         tick();
         pulses += int'(cancel_req);
      end
      check("cancel_pulses", pulses, 1);
      check("cancel_amount", current_amount, 0);
      cancel_raw = 0;
      repeat (8) tick();

      // two coins same cycle
      press(3'b011, 1'b0, 5'd0, 1'b0);
      check("multi_reject", coin_reject, 1);
      check("multi_valid", coin_valid, 0);
      check("multi_amount", current_amount, 0);
      release_coins();

      // build up to 29
      repeat (5) coin(3'b100);
      coin(3'b010);
      coin(3'b010);
      check("fill_amount", current_amount, 29);

      press(3'b100, 1'b0, 5'd0, 1'b0);
      check("over_reject", coin_reject, 1);
      check("over_amount", current_amount, 29);
      release_coins();
      press(3'b010, 1'b0, 5'd0, 1'b0);
      check("max_valid", coin_valid, 1);
      check("max_amount", current_amount, 31);
      release_coins();

      // clear with a coin event
      press(3'b001, 1'b0, 5'd0, 1'b1);
      check("clr_reject", coin_reject, 1);
      check("clr_valid", coin_valid, 0);
      check("clr_amount", current_amount, 0);
      release_coins();
      coin(3'b010);
      clear = 1;
      deduct(5'd1);
      clear = 0;
      check("clr_ded_err", deduct_err, 1);
      check("clr_ded_ack", deduct_ack, 0);
      check("clr_ded_amount", current_amount, 0);

      // reset mid-debounce with raw held high
      c1 = 1;
      repeat (4) tick();
      reset = 1;
      tick();
      check("rst_mid_pulses", {coin_valid, coin_reject, deduct_ack,
                               deduct_err, cancel_req}, 0);
      check("rst_mid_amount", current_amount, 0);
      tick();
      reset = 0;
      pulses = 0;
      repeat (6) begin
         tick();
         pulses += int'(coin_valid);
      end
      check("rst_no_early", pulses, 0);
      tick();
      check("rst_late_valid", coin_valid, 1);
      check("rst_late_amount", current_amount, 1);
      release_coins();

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule

// File: doc/coin_input_module.md
COIN_INPUT_MODULE -- requirements
Module: coin_input_module

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4: consecutive stable synchronized samples needed to accept a level change on any raw input.
REQ-002 Parameter MAX_AMOUNT, default 5'd31: credit ceiling.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 coin_1_raw, coin_2_raw, coin_5_raw  input  1 each  asynchronous, bouncy coin-sensor levels; high while a coin passes.
REQ-006 cancel_raw  input  1  asynchronous, bouncy cancel push-button.
REQ-007 clear  input  1  controller request: zero the credit.
REQ-008 deduct_valid  input  1  controller request: subtract deduct_value from the credit.
REQ-009 deduct_value  input  5  price to subtract.
REQ-010 current_amount  output  5  registered credit; feeds the display block.
REQ-011 coin_valid  output  1  one-cycle pulse: a coin was accepted.
REQ-012 coin_value  output  5  value of the accepted coin; valid with coin_valid, else 0.
REQ-013 coin_reject  output  1  one-cycle pulse: a coin event was refused and is physically returned.
REQ-014 deduct_ack  output  1  one-cycle pulse: deduction applied.
REQ-015 deduct_err  output  1  one-cycle pulse: deduction refused.
REQ-016 cancel_req  output  1  one-cycle pulse on a debounced cancel press.

Function
REQ-017 Each raw input passes through a 2-flop synchronizer, then a per-input debounce counter.
REQ-018 The debounce counter increments while the synchronized level differs from the debounced level and zeroes when they match; the debounced level flips when the count reaches DEBOUNCE_CYCLES.
REQ-019 A coin event or cancel event is the debounced rising edge only; falling edges generate nothing.
REQ-020 Latency: raw input held high from edge N produces its event pulse, and for coins the updated current_amount, at edge N+2+DEBOUNCE_CYCLES.
REQ-021 Coin values: coin_1 = 1, coin_2 = 2, coin_5 = 5.
REQ-022 Two or more coin events in the same cycle: all are rejected, giving one coin_reject pulse and no credit change.
REQ-023 A single coin event is accepted only if (amount after this cycle's deduction) + value <= MAX_AMOUNT; otherwise coin_reject is pulsed and the credit is unchanged by the coin.
REQ-024 Deduction: if deduct_valid and deduct_value <= current_amount, the credit is reduced by deduct_value and deduct_ack is pulsed; otherwise deduct_err is pulsed and the credit is unchanged.
REQ-025 Same-cycle deduction and accepted coin: new amount = current_amount - deduct_value + coin value, with the deduction checked first.
REQ-026 clear has the highest priority: current_amount becomes 0; any coin event that cycle is rejected (coin_reject); deduct_valid that cycle is answered with deduct_err.
REQ-027 Arithmetic uses 6-bit intermediates; current_amount never wraps and never exceeds MAX_AMOUNT.
REQ-028 cancel_req is independent of the credit path; the controller issues clear itself.
REQ-029 All outputs are registered, and pulse outputs are high for exactly one cycle per event.

Reset
REQ-030 On reset, current_amount = 0, all pulse outputs = 0, coin_value = 0, synchronizers and debounced levels = 0, and counters = 0.
REQ-031 Reset asserted mid-debounce or mid-coin discards the pending event; a raw input still high after reset produces an event only after the full REQ-020 latency.

Verification
REQ-032 coin_5_raw held high from edge 10, DEBOUNCE_CYCLES=4 -> coin_valid=1 and coin_value=5 at edge 16, current_amount 0->5; no second event while high.
REQ-033 coin_2_raw toggled every cycle for 3 cycles, then held high -> exactly one coin_valid, amount +2.
REQ-034 Amount 29, coin_5 event -> coin_reject=1, amount stays 29; then coin_2 event -> amount 31.
REQ-035 Amount 7, deduct_valid with value 5 in the same cycle as a coin_1 event -> deduct_ack=1, coin_valid=1, amount 3; then deduct value 4 -> deduct_err=1, amount 3.
REQ-036 coin_1 and coin_2 debounced in the same cycle -> a single coin_reject, amount unchanged; clear with a coin event -> amount 0, coin_reject=1.
REQ-037 Reset pulsed two cycles into a coin debounce, raw input held high -> no event before 2+DEBOUNCE_CYCLES cycles after reset deasserts; all outputs 0 during reset.
